// File: rtl/mer_meas_pkg.sv
// Shared definitions for the MER power measurement block: FSM states and
// the width relations between sample, square and accumulator.
package mer_meas_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SKIP,
        S_ACCUM,
        S_DONE
    } state_t;

    localparam int DEFAULT_DATA_WIDTH = 18;
    localparam int DEFAULT_LOG2_N     = 16;
    localparam int DEFAULT_SKIP       = 4;

    localparam int SQ_WIDTH  = 2 * DEFAULT_DATA_WIDTH;
    localparam int ACC_WIDTH = SQ_WIDTH + DEFAULT_LOG2_N;

    function automatic int sq_width(input int data_width);
        return 2 * data_width;
    endfunction

    function automatic int acc_width(input int data_width, input int log2_n);
        return sq_width(data_width) + log2_n;
    endfunction

endpackage

// File: rtl/power_accumulator.sv
// Squares a signed sample and sums it into a wide register. The next-sum
// value is exported so the caller can capture the final total on the last add.
module power_accumulator
    import mer_meas_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int LOG2_N     = DEFAULT_LOG2_N
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          clear,
    input  logic                                          enable,
    input  logic signed [DATA_WIDTH-1:0]                  sample,
    output logic        [acc_width(DATA_WIDTH, LOG2_N)-1:0] sum
);

    localparam int SQ_W  = sq_width(DATA_WIDTH);
    localparam int ACC_W = acc_width(DATA_WIDTH, LOG2_N);

    logic signed [SQ_W-1:0]  square;
    logic        [ACC_W-1:0] acc;

    // Sign-extend before multiplying so the most negative sample squares exactly.
    always_comb begin
        square = SQ_W'(sample) * SQ_W'(sample);
        sum    = acc + ACC_W'($unsigned(square));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/mer_power_accumulator.sv
// Measures mean-square error, mean-square signal and peak |error| over a
// window of 2^LOG2_N enabled symbols, after discarding SKIP symbols.
module mer_power_accumulator
    import mer_meas_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int LOG2_N     = DEFAULT_LOG2_N,
    parameter int SKIP       = DEFAULT_SKIP
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clk_en,
    input  logic                         start,
    input  logic signed [DATA_WIDTH-1:0] errorless_decision_variable,
    input  logic signed [DATA_WIDTH-1:0] error,
    output logic                         busy,
    output logic                         done,
    output logic [2*DATA_WIDTH-1:0]      mean_sq_error,
    output logic [2*DATA_WIDTH-1:0]      mean_sq_signal,
    output logic [DATA_WIDTH-1:0]        peak_error
);

    localparam int SQ_W    = sq_width(DATA_WIDTH);
    localparam int ACC_W   = acc_width(DATA_WIDTH, LOG2_N);
    localparam int WINDOW  = 1 << LOG2_N;
    localparam int CNT_MAX = (SKIP > WINDOW) ? SKIP : WINDOW;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SKIP_LAST  = CNT_W'(SKIP - 1);
    localparam logic [CNT_W-1:0] ACCUM_LAST = CNT_W'(WINDOW - 1);
    localparam state_t           FIRST_BUSY = (SKIP == 0) ? S_ACCUM : S_SKIP;

    state_t                  state;
    logic [CNT_W-1:0]        count;
    logic [DATA_WIDTH-1:0]   peak;
    logic [DATA_WIDTH-1:0]   abs_error;
    logic [DATA_WIDTH-1:0]   peak_next;
    logic [ACC_W-1:0]        err_sum;
    logic [ACC_W-1:0]        sig_sum;
    logic                    accept;
    logic                    accum_en;

    // Start is honoured in IDLE/DONE regardless of clk_en; it also clears the accumulators.
    always_comb begin
        accept    = start && ((state == S_IDLE) || (state == S_DONE));
        accum_en  = clk_en && (state == S_ACCUM);
        abs_error = error[DATA_WIDTH-1] ? $unsigned(-error) : $unsigned(error);
        peak_next = (abs_error > peak) ? abs_error : peak;
    end

    power_accumulator #(
        .DATA_WIDTH (DATA_WIDTH),
        .LOG2_N     (LOG2_N)
    ) u_error_acc (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept),
        .enable (accum_en),
        .sample (error),
        .sum    (err_sum)
    );

    power_accumulator #(
        .DATA_WIDTH (DATA_WIDTH),
        .LOG2_N     (LOG2_N)
    ) u_signal_acc (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept),
        .enable (accum_en),
        .sample (errorless_decision_variable),
        .sum    (sig_sum)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            count          <= '0;
            peak           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            mean_sq_error  <= '0;
            mean_sq_signal <= '0;
            peak_error     <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        state <= FIRST_BUSY;
                        count <= '0;
                        peak  <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                S_SKIP: begin
                    if (clk_en) begin
                        if (count == SKIP_LAST) begin
                            state <= S_ACCUM;
                            count <= '0;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                end
                S_ACCUM: begin
                    if (clk_en) begin
                        peak <= peak_next;
                        if (count == ACCUM_LAST) begin
                            // The last square is still in flight, so results come from the next-sum values.
                            state          <= S_DONE;
                            count          <= '0;
                            busy           <= 1'b0;
                            done           <= 1'b1;
                            mean_sq_error  <= SQ_W'(err_sum >> LOG2_N);
                            mean_sq_signal <= SQ_W'(sig_sum >> LOG2_N);
                            peak_error     <= peak_next;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
